// File: rtl/mem_ext_loader_if.sv
// Bus bundle between the host-side loader and the CPU external memory ports.
// LOADER_CHECKSUM_EN adds the dump_sum output.
interface mem_ext_loader_if #(
    parameter int CNT_W = 10
);
    logic             cfg_start;
    logic [CNT_W-1:0] cfg_imem_words;
    logic [CNT_W-1:0] cfg_dmem_words;
    logic [31:0]      cfg_run_cycles;
    logic [CNT_W-1:0] cfg_dump_words;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             enable;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;
    logic             busy;
    logic             done;
    logic [2:0]       dbg_state;
`ifdef LOADER_CHECKSUM_EN
    logic [63:0]      dump_sum;
`endif

    // Both streams are valid/ready: a word moves on a cycle where valid and ready are both high;
    // the sender holds valid and data stable until that cycle.
    modport master (
        input  cfg_start, cfg_imem_words, cfg_dmem_words, cfg_run_cycles, cfg_dump_words,
        input  in_valid, in_data, out_ready, rdata_ext_2,
        output in_ready, out_valid, out_data, enable,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        output busy, done, dbg_state
`ifdef LOADER_CHECKSUM_EN
        , output dump_sum
`endif
    );

    modport slave (
        output cfg_start, cfg_imem_words, cfg_dmem_words, cfg_run_cycles, cfg_dump_words,
        output in_valid, in_data, out_ready, rdata_ext_2,
        input  in_ready, out_valid, out_data, enable,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        input  busy, done, dbg_state
`ifdef LOADER_CHECKSUM_EN
        , input dump_sum
`endif
    );
endinterface

// File: rtl/mem_ext_loader.sv
// Loads imem/dmem from a stream, runs the core for N cycles, then streams a dmem window back.
// Optional LOADER_CHECKSUM_EN: modulo-2^64 sum of accepted dump words on dump_sum.
module mem_ext_loader #(
    parameter int          CNT_W     = 10,
    parameter int          READ_LAT  = 1,
    parameter logic [63:0] DUMP_BASE = 64'd0
) (
    input logic           clk,
    input logic           arst_n,
    mem_ext_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_I    = 3'd1,
        LOAD_D    = 3'd2,
        RUN       = 3'd3,
        DUMP_RD   = 3'd4,
        DUMP_WAIT = 3'd5,
        DUMP_OUT  = 3'd6,
        DONE      = 3'd7
    } state_t;

    localparam int               LAT_W   = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] K_ONE   = CNT_W'(1);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] imem_n_q, imem_n_d;
    logic [CNT_W-1:0] dmem_n_q, dmem_n_d;
    logic [CNT_W-1:0] dump_n_q, dump_n_d;
    logic [31:0]      run_q, run_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             first_q, first_d;
    logic [63:0]      odata_q, odata_d;

    // First phase, in load/run/dump order, whose count is nonzero.
    function automatic state_t pick(input logic i_nz, input logic d_nz,
                                    input logic r_nz, input logic u_nz);
        if (i_nz)      return LOAD_I;
        else if (d_nz) return LOAD_D;
        else if (r_nz) return RUN;
        else if (u_nz) return DUMP_RD;
        else           return DONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        imem_n_d = imem_n_q;
        dmem_n_d = dmem_n_q;
        dump_n_d = dump_n_q;
        run_d    = run_q;
        lat_d    = lat_q;
        first_d  = 1'b0;
        odata_d  = odata_q;

        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_data    = odata_q;
        bus.enable      = 1'b0;
        bus.addr_ext    = 64'd0;
        bus.wen_ext     = 1'b0;
        bus.ren_ext     = 1'b0;
        bus.wdata_ext   = 32'd0;
        bus.addr_ext_2  = 64'd0;
        bus.wen_ext_2   = 1'b0;
        bus.ren_ext_2   = 1'b0;
        bus.wdata_ext_2 = 64'd0;
        bus.busy        = (state_q != IDLE);
        bus.done        = 1'b0;
        bus.dbg_state   = state_q;

        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    imem_n_d = bus.cfg_imem_words;
                    dmem_n_d = bus.cfg_dmem_words;
                    dump_n_d = bus.cfg_dump_words;
                    run_d    = bus.cfg_run_cycles;
                    k_d      = '0;
                    state_d  = pick(bus.cfg_imem_words != '0, bus.cfg_dmem_words != '0,
                                    bus.cfg_run_cycles != 32'd0, bus.cfg_dump_words != '0);
                end
            end
            LOAD_I: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.wen_ext   = 1'b1;
                    bus.addr_ext  = 64'(k_q) << 2;
                    bus.wdata_ext = bus.in_data[31:0];
                    if (k_q == imem_n_q - K_ONE) begin
                        k_d     = '0;
                        state_d = pick(1'b0, dmem_n_q != '0, run_q != 32'd0, dump_n_q != '0);
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end
            end
            LOAD_D: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.wen_ext_2   = 1'b1;
                    bus.addr_ext_2  = 64'(k_q) << 3;
                    bus.wdata_ext_2 = bus.in_data;
                    if (k_q == dmem_n_q - K_ONE) begin
                        k_d     = '0;
                        state_d = pick(1'b0, 1'b0, run_q != 32'd0, dump_n_q != '0);
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end
            end
            RUN: begin
                // run_q was loaded with the cycle count at start and is only consumed here.
                bus.enable = 1'b1;
                if (run_q == 32'd1) begin
                    run_d   = 32'd0;
                    k_d     = '0;
                    state_d = pick(1'b0, 1'b0, 1'b0, dump_n_q != '0);
                end else begin
                    run_d = run_q - 32'd1;
                end
            end
            DUMP_RD: begin
                bus.ren_ext_2  = 1'b1;
                bus.addr_ext_2 = DUMP_BASE + (64'(k_q) << 3);
                if (READ_LAT <= 1) begin
                    state_d = DUMP_OUT;
                    first_d = 1'b1;
                end else begin
                    state_d = DUMP_WAIT;
                    lat_d   = LAT_W'(READ_LAT - 2);
                end
            end
            DUMP_WAIT: begin
                if (lat_q == '0) begin
                    state_d = DUMP_OUT;
                    first_d = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            DUMP_OUT: begin
                // Read data is valid in the first DUMP_OUT cycle; it is passed through and
                // captured then, so a stalled word is held from the register afterwards.
                bus.out_valid = 1'b1;
                if (first_q) begin
                    bus.out_data = bus.rdata_ext_2;
                    odata_d      = bus.rdata_ext_2;
                end
                if (bus.out_ready) begin
                    if (k_q == dump_n_q - K_ONE) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + K_ONE;
                        state_d = DUMP_RD;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            imem_n_q <= '0;
            dmem_n_q <= '0;
            dump_n_q <= '0;
            run_q    <= 32'd0;
            lat_q    <= '0;
            first_q  <= 1'b0;
            odata_q  <= 64'd0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            imem_n_q <= imem_n_d;
            dmem_n_q <= dmem_n_d;
            dump_n_q <= dump_n_d;
            run_q    <= run_d;
            lat_q    <= lat_d;
            first_q  <= first_d;
            odata_q  <= odata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [63:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && bus.cfg_start) begin
            sum_d = 64'd0;
        end else if (state_q == DUMP_OUT && bus.out_ready) begin
            sum_d = sum_q + bus.out_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) sum_q <= 64'd0;
        else         sum_q <= sum_d;
    end

    assign bus.dump_sum = sum_q;
`endif

endmodule

// File: tb/tb_mem_ext_loader.sv
// Bench for mem_ext_loader: table-driven jobs, directed corner sequences and random jobs
// checked against a job-level model of the expected memory traffic and dump stream.
module tb_mem_ext_loader;
  localparam int          CNT_W     = 10;
  localparam int          READ_LAT  = 1;
  localparam logic [63:0] DUMP_BASE = 64'd0;

  logic clk;
  logic arst_n;

  mem_ext_loader_if #(.CNT_W(CNT_W)) bus ();

  mem_ext_loader #(
    .CNT_W    (CNT_W),
    .READ_LAT (READ_LAT),
    .DUMP_BASE(DUMP_BASE)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data SRAM model, one cycle read latency, with a bench-side preload port
  logic [63:0] sram_d [64];
  logic        pre_we;
  logic [5:0]  pre_a;
  logic [63:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) sram_d[pre_a] <= pre_d;
    else if (bus.wen_ext_2) sram_d[bus.addr_ext_2[8:3]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= sram_d[bus.addr_ext_2[8:3]];
  end

  // reference contents of data memory as the host expects them
  logic [63:0] ref_d [64];

  // scoreboard
  logic [63:0] exp_ia[$];
  logic [63:0] exp_iw[$];
  logic [63:0] exp_da[$];
  logic [63:0] exp_dw[$];
  logic [63:0] exp_o[$];
  logic [63:0] fix_w[$];

  int n_vec;
  int n_err;

  typedef struct {
    int ni;
    int nd;
    int nr;
    int nn;
    int hold;
    int exp_busy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      pre_we = 1'b1;
      pre_a  = 6'(i);
      pre_d  = (mode == 1) ? 64'(i + 1) : {$urandom, $urandom};
      ref_d[i] = pre_d;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic next_word(output logic [63:0] w);
    if (fix_w.size() > 0) w = fix_w.pop_front();
    else w = {$urandom, $urandom};
  endtask

  // vm: 0 valid held, 1 random, 2 toggling; rm: 0 ready held, 1 random, 2 stall word 2
  task automatic run_job(input int ni, input int nd, input int nr, input int nn,
                         input int vm, input int rm, input int hold, input int noise,
                         input int abort_at, input int exp_busy);
    logic [63:0] stim[$];
    logic [63:0] w;
    logic [63:0] prev_data;
    logic [63:0] sum_exp;
    int cyc, busy_cyc, done_cnt, post, n_iw, n_dw, en_cyc, n_out, rd_idx, stall_left;
    bit seen, acc, tog, prev_stall;

    exp_ia.delete(); exp_iw.delete(); exp_da.delete(); exp_dw.delete(); exp_o.delete();
    for (int i = 0; i < ni; i++) begin
      next_word(w);
      stim.push_back(w);
      exp_ia.push_back(64'(4 * i));
      exp_iw.push_back({32'd0, w[31:0]});
    end
    for (int i = 0; i < nd; i++) begin
      next_word(w);
      stim.push_back(w);
      exp_da.push_back(64'(8 * i));
      exp_dw.push_back(w);
      ref_d[i] = w;
    end
    for (int j = 0; j < nn; j++) exp_o.push_back(ref_d[int'(DUMP_BASE / 8) + j]);

    cyc = 0; busy_cyc = 0; done_cnt = 0; post = 0; n_iw = 0; n_dw = 0; en_cyc = 0;
    n_out = 0; rd_idx = 0; stall_left = 3; seen = 0; tog = 1; prev_stall = 0;
    prev_data = '0; sum_exp = '0;

    @(posedge clk); #1;
    bus.cfg_imem_words = CNT_W'(ni);
    bus.cfg_dmem_words = CNT_W'(nd);
    bus.cfg_run_cycles = 32'(nr);
    bus.cfg_dump_words = CNT_W'(nn);
    bus.cfg_start      = 1'b1;
    tog = ~tog;
    bus.in_valid  = (stim.size() > 0) && (vm == 0 || (vm == 1 && $urandom_range(0, 1) == 1) || (vm == 2 && tog));
    bus.in_data   = (stim.size() > 0) ? stim[0] : 64'd0;
    bus.out_ready = 1'b1;

    while (cyc < 3000 && !(seen && post >= 3)) begin
      @(negedge clk);
      cyc++;
      if (seen) post++;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
`ifdef LOADER_CHECKSUM_EN
        chk("dump_sum", bus.dump_sum, sum_exp);
`endif
        seen = 1;
      end
      if (bus.wen_ext) begin
        n_iw++;
        if (exp_ia.size() == 0) chk("imem_extra_write", 64'(n_iw), 64'(ni));
        else begin
          chk("imem_addr", bus.addr_ext, exp_ia.pop_front());
          chk("imem_data", 64'(bus.wdata_ext), exp_iw.pop_front());
        end
      end
      if (bus.wen_ext_2) begin
        n_dw++;
        if (exp_da.size() == 0) chk("dmem_extra_write", 64'(n_dw), 64'(nd));
        else begin
          chk("dmem_addr", bus.addr_ext_2, exp_da.pop_front());
          chk("dmem_data", bus.wdata_ext_2, exp_dw.pop_front());
        end
      end
      if (bus.ren_ext_2) begin
        chk("dump_rd_addr", bus.addr_ext_2, DUMP_BASE + 64'(8 * rd_idx));
        rd_idx++;
      end
      if (bus.enable) begin
        en_cyc++;
        chk("ext_quiet_in_run", {61'd0, bus.wen_ext, bus.wen_ext_2, bus.ren_ext_2}, 64'd0);
      end
      if (prev_stall) begin
        chk("out_valid_held", 64'(bus.out_valid), 64'd1);
        chk("out_data_held", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        sum_exp = sum_exp + bus.out_data;
        if (exp_o.size() == 0) chk("dump_extra_word", 64'(n_out), 64'(nn));
        else chk("dump_data", bus.out_data, exp_o.pop_front());
      end
      if (abort_at == cyc) begin
        chk("pre_rst_write_active", 64'(bus.wen_ext_2), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("rst_strobes", {55'd0, bus.enable, bus.wen_ext, bus.ren_ext, bus.wen_ext_2,
                            bus.ren_ext_2, bus.in_ready, bus.out_valid, bus.busy, bus.done}, 64'd0);
        chk("rst_addr_ext_2", bus.addr_ext_2, 64'd0);
        chk("rst_wdata_ext_2", bus.wdata_ext_2, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        bus.in_valid  = 1'b0;
        bus.cfg_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        exp_ia.delete(); exp_iw.delete(); exp_da.delete(); exp_dw.delete(); exp_o.delete();
        return;
      end
      acc = bus.in_valid && bus.in_ready;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (rm == 2 && bus.out_valid && !bus.out_ready && n_out == 1) stall_left--;

      @(posedge clk); #1;
      if (acc) void'(stim.pop_front());
      tog = ~tog;
      bus.in_valid = (stim.size() > 0) && (vm == 0 || (vm == 1 && $urandom_range(0, 1) == 1) || (vm == 2 && tog));
      bus.in_data  = (stim.size() > 0) ? stim[0] : {$urandom, $urandom};
      case (rm)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        default: bus.out_ready = !(n_out == 1 && stall_left > 0);
      endcase
      if (cyc >= ((hold != 0) ? 2 : 1)) begin
        bus.cfg_start      = (noise != 0 && cyc == 2);
        bus.cfg_imem_words = CNT_W'($urandom_range(1, 9));
        bus.cfg_dmem_words = CNT_W'($urandom_range(1, 9));
        bus.cfg_run_cycles = 32'($urandom_range(1, 9));
        bus.cfg_dump_words = CNT_W'($urandom_range(1, 9));
      end
    end

    bus.in_valid  = 1'b0;
    bus.cfg_start = 1'b0;
    chk("job_finished", 64'(seen), 64'd1);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("imem_writes", 64'(n_iw), 64'(ni));
    chk("dmem_writes", 64'(n_dw), 64'(nd));
    chk("enable_cycles", 64'(en_cyc), 64'(nr));
    chk("dump_words", 64'(n_out), 64'(nn));
    chk("ren_ext_tied", 64'(bus.ren_ext), 64'd0);
    if (exp_busy >= 0) chk("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{ni: 0, nd: 0, nr: 0, nn: 0, hold: 1, exp_busy: 1};
    tbl[1] = '{ni: 3, nd: 0, nr: 0, nn: 0, hold: 0, exp_busy: 4};
    tbl[2] = '{ni: 0, nd: 2, nr: 0, nn: 0, hold: 0, exp_busy: 3};
    tbl[3] = '{ni: 0, nd: 0, nr: 5, nn: 0, hold: 0, exp_busy: 6};
    tbl[4] = '{ni: 0, nd: 0, nr: 0, nn: 4, hold: 0, exp_busy: 9};
    tbl[5] = '{ni: 3, nd: 2, nr: 5, nn: 4, hold: 0, exp_busy: 19};
    tbl[6] = '{ni: 1, nd: 1, nr: 1, nn: 1, hold: 0, exp_busy: 6};
    tbl[7] = '{ni: 0, nd: 3, nr: 0, nn: 2, hold: 0, exp_busy: 8};

    arst_n = 1'b0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.cfg_start = 1'b0;
    bus.cfg_imem_words = '0; bus.cfg_dmem_words = '0;
    bus.cfg_run_cycles = '0; bus.cfg_dump_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {54'd0, bus.enable, bus.wen_ext, bus.ren_ext, bus.wen_ext_2,
                          bus.ren_ext_2, bus.in_ready, bus.out_valid, bus.busy, bus.done,
                          1'b0}, 64'd0);
    chk("reset_addr_ext", bus.addr_ext, 64'd0);
    chk("reset_wdata_ext", 64'(bus.wdata_ext), 64'd0);
    chk("reset_out_data", bus.out_data, 64'd0);
    arst_n = 1'b1;

    preload(0);
    for (int i = 0; i < 8; i++)
      run_job(tbl[i].ni, tbl[i].nd, tbl[i].nr, tbl[i].nn, 0, 0, tbl[i].hold, 0, 0,
              tbl[i].exp_busy);

    // directed: fixed instruction words, toggling data valid, run length, stalled dump
    fix_w.push_back(64'h0000_0000_0000_0013);
    fix_w.push_back(64'h0000_0000_0010_0093);
    fix_w.push_back(64'h0000_0000_0020_8113);
    run_job(3, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    run_job(0, 2, 0, 0, 2, 0, 0, 0, 0, 4);
    run_job(0, 0, 5, 0, 0, 0, 0, 0, 0, 6);
    preload(1);
    run_job(0, 0, 0, 4, 0, 2, 0, 0, 0, 12);
    run_job(4, 1, 2, 1, 0, 0, 0, 1, 0, 4 + 1 + 2 + 2 + 1);

    // reset in the middle of the data load, then a clean restart
    run_job(2, 6, 0, 0, 0, 0, 0, 0, 6, -1);
    run_job(2, 6, 0, 4, 0, 0, 0, 0, 0, 17);

    for (int r = 0; r < 24; r++) begin
      int ni, nd, nr, nn;
      ni = $urandom_range(0, 6);
      nd = $urandom_range(0, 6);
      nr = $urandom_range(0, 6);
      nn = $urandom_range(0, 6);
      run_job(ni, nd, nr, nn, $urandom_range(0, 1), $urandom_range(0, 1), 0,
              (ni >= 2) ? $urandom_range(0, 1) : 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_ext_loader.md
Name: mem_ext_loader

Overview:
Host-side initiator for the CPU's external memory ports. It streams a program into instruction memory and an initial image into data memory. It then holds the core's enable high for a programmed number of cycles, and finally reads a window of data memory back out on a stream. It sits between the testbench/host link and the cpu top level, driving every *_ext / *_ext_2 input and consuming rdata_ext_2.

Parameters:
CNT_W, 10, width of all word-count configuration inputs and internal word counters
READ_LAT, 1, cycles from ren_ext_2 assertion to valid rdata_ext_2 (data SRAM read latency)
DUMP_BASE, 0, byte address of the first data-memory word read back

Ports:
clk  in  1  main clock
arst_n  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle start pulse; ignored while busy
cfg_imem_words  in  CNT_W  number of 32-bit instruction words to load
cfg_dmem_words  in  CNT_W  number of 64-bit data words to load
cfg_run_cycles  in  32  cycles to hold enable high
cfg_dump_words  in  CNT_W  number of 64-bit words to read back
in_valid  in  1  load stream word valid
in_ready  out  1  load stream word accepted this cycle when in_valid is also high
in_data  in  64  load word; only [31:0] is used during the instruction phase
out_valid  out  1  dump word valid
out_ready  in  1  downstream accepts dump word
out_data  out  64  dump word
enable  out  1  to cpu enable
addr_ext  out  64  instruction memory external address (byte)
wen_ext  out  1  instruction memory external write enable
ren_ext  out  1  instruction memory external read enable, tied 0
wdata_ext  out  32  instruction memory external write data
addr_ext_2  out  64  data memory external address (byte)
wen_ext_2  out  1  data memory external write enable
ren_ext_2  out  1  data memory external read enable
wdata_ext_2  out  64  data memory external write data
rdata_ext_2  in  64  data memory external read data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on the DONE to IDLE transition

Behaviour:
- Single clock clk; reset is asynchronous, active-low on arst_n.
- Reset: FSM=IDLE; all outputs 0; counters and latched configuration cleared.
- Reset asserted mid-operation aborts immediately; no partial write is completed.
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE: on cfg_start, latch all cfg_* inputs, clear the word counter, go to the first phase with a nonzero count, in order LOAD_I, LOAD_D, RUN, DUMP_RD. If every count is zero, go to DONE.
- LOAD_I:
  - in_ready=1.
  - On in_valid&in_ready, in the same cycle drive wen_ext=1, addr_ext=4*k, wdata_ext=in_data[31:0] (combinational from the handshake), then k++.
  - After word cfg_imem_words-1 is accepted, move to the next nonzero phase.
- LOAD_D: same as LOAD_I, but drives wen_ext_2=1, addr_ext_2=8*k, wdata_ext_2=in_data.
- in_ready=0 in all other states; in_valid is ignored there.
- RUN:
  - enable=1 for exactly cfg_run_cycles consecutive cycles, counted by a 32-bit down-counter.
  - enable=0 in every other state.
  - All ext write/read enables are 0 while enable=1.
- DUMP_RD:
  - ren_ext_2=1 for one cycle, addr_ext_2=DUMP_BASE+8*k.
  - Then DUMP_WAIT for READ_LAT-1 cycles (0 cycles when READ_LAT=1).
  - Capture rdata_ext_2 into the out_data register on the cycle it is valid, then go to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - On handshake: k++; if k==cfg_dump_words go to DONE, else go to DUMP_RD.
  - Throughput: one word per READ_LAT+1 cycles at best; no read pipelining.
- DONE: pulse done for one cycle, then IDLE.
- Address arithmetic: 64-bit, counter zero-extended, no wrap check. CNT_W bounds the range.
- cfg_start asserted in the same cycle as DONE→IDLE is ignored; it must be re-issued.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: adds output port dump_sum[63:0], the modulo-2^64 sum of all dump words accepted on out_valid&out_ready. It is cleared on cfg_start and on reset, and is valid when done pulses.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Load 3 instruction words 0x00000013, 0x00100093, 0x00208113 with in_valid held high → wen_ext high for 3 consecutive cycles at addr_ext 0, 4, 8; wdata_ext matches each word.
- Load 2 data words with in_valid toggling 1,0,1 → exactly 2 wen_ext_2 pulses, at addr_ext_2 0 and 8; no write in the gap cycle.
- cfg_run_cycles=5 → enable high for exactly 5 cycles; no ext enable is active during those cycles.
- Dump 4 words, DUMP_BASE=0, memory preloaded 1, 2, 3, 4; out_ready low for 3 cycles on word 2 → out_data sequence 1, 2, 3, 4; word 2 held stable while stalled; done pulses once.
- All counts 0 → busy high for 1 cycle (DONE), done pulses, no memory activity. cfg_start during LOAD_I → ignored.
- Assert arst_n low mid-LOAD_D → all outputs 0 immediately, FSM in IDLE; a new cfg_start restarts cleanly from k=0.
